// File: rtl/operand_b_decoder_if.sv
// Fetch/decode bus between the B-operand decoder, its instruction ROM and the datapath.
// The master modport is the decoder side; slave is the ROM/datapath side.
interface operand_b_decoder_if;
  logic        stall;
  logic        jmp;
  logic [7:0]  jmp_addr;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [1:0]  sel_b;
  logic [7:0]  im;
  logic [3:0]  alu_op;
  logic        op_valid;
  logic        illegal;

  modport master (
    input  stall, jmp, jmp_addr, rom_data,
    output rom_addr, sel_b, im, alu_op, op_valid, illegal
  );

  modport slave (
    output stall, jmp, jmp_addr, rom_data,
    input  rom_addr, sel_b, im, alu_op, op_valid, illegal
  );
endinterface

// File: rtl/operand_b_decoder.sv
// Fetch/decode front end: walks the PC over a synchronous ROM and presents
// B-operand select, immediate and ALU opcode through a valid/stall handshake.
module operand_b_decoder (
  input  logic                 clk,
  input  logic                 rst,
  operand_b_decoder_if.master  bus
);

  typedef enum logic [1:0] {FETCH, LOAD, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  pc, pc_nxt;
  logic        load_en;
  logic [1:0]  sel_b_q;
  logic [7:0]  im_q;
  logic [3:0]  alu_op_q;
  logic        illegal_q;
  logic [1:0]  rsvd_unused;

  // Reserved code 11 falls back to the zero operand so the datapath stays benign.
  function automatic logic [1:0] decode_sel(input logic [1:0] src);
    return (src == 2'b11) ? 2'b01 : src;
  endfunction

  assign rsvd_unused = bus.rom_data[13:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 8'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_en   = 1'b0;
    case (state)
      FETCH: state_nxt = LOAD;
      LOAD: begin
        state_nxt = ISSUE;
        load_en   = 1'b1;
      end
      ISSUE: begin
        if (!bus.stall) begin
          state_nxt = FETCH;
          pc_nxt    = pc + 8'd1;
        end
      end
      default: state_nxt = FETCH;
    endcase
    // A jump overrides everything: in-flight fetches and presented words are dropped.
    if (bus.jmp) begin
      state_nxt = FETCH;
      pc_nxt    = bus.jmp_addr;
      load_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_b_q   <= 2'b01;
      im_q      <= 8'd0;
      alu_op_q  <= 4'd0;
      illegal_q <= 1'b0;
    end else if (load_en) begin
      sel_b_q   <= decode_sel(bus.rom_data[15:14]);
      im_q      <= bus.rom_data[7:0];
      alu_op_q  <= bus.rom_data[11:8];
      illegal_q <= (bus.rom_data[15:14] == 2'b11);
    end
  end

  assign bus.rom_addr = pc;
  assign bus.sel_b    = sel_b_q;
  assign bus.im       = im_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.illegal  = illegal_q;
  assign bus.op_valid = (state == ISSUE);

endmodule

// File: tb/tb_operand_b_decoder.sv
// Bench for operand_b_decoder: synchronous ROM model plus an instruction-level
// reference (expected address sequence and field decode) checked per scenario.
module tb_operand_b_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [15:0] rom [256];

  operand_b_decoder_if bus();

  operand_b_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM answers one cycle after it samples the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Reference decode from the field rules, using plain arithmetic.
  function automatic logic [1:0] m_sel(input logic [15:0] w);
    int src;
    src = int'(w) / 16384;
    return (src == 3) ? 2'd1 : 2'(src);
  endfunction
  function automatic logic m_ill(input logic [15:0] w);
    return (int'(w) / 16384) == 3;
  endfunction
  function automatic logic [7:0] m_im(input logic [15:0] w);
    return 8'(int'(w) % 256);
  endfunction
  function automatic logic [3:0] m_op(input logic [15:0] w);
    return 4'((int'(w) / 256) % 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for op_valid; reports the number of edges taken.
  task automatic wait_valid(output int cyc, output bit timeout);
    cyc = 0;
    while (!bus.op_valid && cyc < 12) begin
      tick();
      cyc++;
    end
    timeout = !bus.op_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.rom_addr !== 8'h00) begin bad++; $display("FAIL reset_rom_addr got=%h want=00", bus.rom_addr); end
    total++; if (bus.sel_b !== 2'b01) begin bad++; $display("FAIL reset_sel_b got=%b want=01", bus.sel_b); end
    total++; if (bus.im !== 8'h00) begin bad++; $display("FAIL reset_im got=%h want=00", bus.im); end
    total++; if (bus.alu_op !== 4'h0) begin bad++; $display("FAIL reset_alu_op got=%h want=0", bus.alu_op); end
    total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%b want=0", bus.op_valid); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.illegal); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    tick();
    total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL first_edge1_valid got=%b want=0", bus.op_valid); end
    tick();
    total++; if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL first_edge2_valid got=%b want=1", bus.op_valid); end
    total++; if (bus.sel_b !== 2'b10) begin bad++; $display("FAIL first_sel_b got=%b want=10", bus.sel_b); end
    total++; if (bus.im !== 8'h05) begin bad++; $display("FAIL first_im got=%h want=05", bus.im); end
    total++; if (bus.alu_op !== 4'h3) begin bad++; $display("FAIL first_alu_op got=%h want=3", bus.alu_op); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL first_illegal got=%b want=0", bus.illegal); end
    tick();
    total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL first_valid_one_cycle got=%b want=0", bus.op_valid); end
    total++; if (bus.rom_addr !== 8'h01) begin bad++; $display("FAIL first_next_addr got=%h want=01", bus.rom_addr); end
  endtask

  task automatic test_sequence();
    logic [1:0] es [3];
    logic       ei [3];
    int cyc;
    bit to;
    es = '{2'b00, 2'b01, 2'b01};
    ei = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      wait_valid(cyc, to);
      total++; if (to || cyc != 2) begin bad++; $display("FAIL seq_latency[%0d] got=%0d want=2", i, cyc); end
      total++; if (bus.rom_addr !== 8'(i + 1)) begin bad++; $display("FAIL seq_addr[%0d] got=%h want=%h", i, bus.rom_addr, 8'(i + 1)); end
      total++; if (bus.sel_b !== es[i]) begin bad++; $display("FAIL seq_sel_b[%0d] got=%b want=%b", i, bus.sel_b, es[i]); end
      total++; if (bus.illegal !== ei[i]) begin bad++; $display("FAIL seq_illegal[%0d] got=%b want=%b", i, bus.illegal, ei[i]); end
      tick();
    end
    total++; if (bus.im !== 8'hAA) begin bad++; $display("FAIL seq_im_third got=%h want=AA", bus.im); end
  endtask

  task automatic test_stall();
    int cyc;
    int high;
    bit to;
    wait_valid(cyc, to);
    total++; if (to) begin bad++; $display("FAIL stall_wait got=timeout want=valid"); end
    bus.stall = 1'b1;
    high = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.op_valid) high++;
      total++;
      if (bus.sel_b !== 2'b10 || bus.im !== 8'hFF || bus.alu_op !== 4'h1 || bus.rom_addr !== 8'h04) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=%b/%h/%h/%h want=10/ff/1/04", i, bus.sel_b, bus.im, bus.alu_op, bus.rom_addr);
      end
    end
    bus.stall = 1'b0;
    tick();
    total++; if (high != 5) begin bad++; $display("FAIL stall_valid_cycles got=%0d want=5", high); end
    total++; if (bus.op_valid !== 1'b0 || bus.rom_addr !== 8'h05) begin bad++; $display("FAIL stall_release got=%b/%h want=0/05", bus.op_valid, bus.rom_addr); end
  endtask

  task automatic test_jump();
    int cyc;
    bit to;
    for (int i = 0; i < 2; i++) begin
      wait_valid(cyc, to);
      tick();
    end
    total++; if (bus.rom_addr !== 8'h07) begin bad++; $display("FAIL jump_pre_addr got=%h want=07", bus.rom_addr); end
    tick();
    bus.jmp = 1'b1;
    bus.jmp_addr = 8'h40;
    tick();
    bus.jmp = 1'b0;
    total++; if (bus.op_valid !== 1'b0 || bus.rom_addr !== 8'h40) begin bad++; $display("FAIL jump_fetch got=%b/%h want=0/40", bus.op_valid, bus.rom_addr); end
    wait_valid(cyc, to);
    total++; if (to || cyc != 2) begin bad++; $display("FAIL jump_latency got=%0d want=2", cyc); end
    total++;
    if (bus.im !== m_im(rom[8'h40]) || bus.alu_op !== m_op(rom[8'h40]) || bus.sel_b !== m_sel(rom[8'h40])) begin
      bad++;
      $display("FAIL jump_target_word got=%b/%h/%h want=%b/%h/%h", bus.sel_b, bus.im, bus.alu_op, m_sel(rom[8'h40]), m_im(rom[8'h40]), m_op(rom[8'h40]));
    end
    tick();
  endtask

  task automatic test_wrap();
    int cyc;
    bit to;
    bus.jmp = 1'b1;
    bus.jmp_addr = 8'hFE;
    tick();
    bus.jmp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_valid(cyc, to);
      total++; if (to || bus.im !== m_im(rom[8'(254 + i)])) begin bad++; $display("FAIL wrap_word[%0d] got=%h want=%h", i, bus.im, m_im(rom[8'(254 + i)])); end
      tick();
    end
    total++; if (bus.rom_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr got=%h want=00", bus.rom_addr); end
    wait_valid(cyc, to);
    total++; if (to || bus.sel_b !== 2'b10 || bus.im !== 8'h05) begin bad++; $display("FAIL wrap_rom0 got=%b/%h want=10/05", bus.sel_b, bus.im); end
  endtask

  task automatic test_jmp_in_issue();
    int cyc;
    bit to;
    bus.jmp = 1'b1;
    bus.jmp_addr = 8'h20;
    bus.stall = 1'b1;
    tick();
    bus.jmp = 1'b0;
    bus.stall = 1'b0;
    total++; if (bus.op_valid !== 1'b0 || bus.rom_addr !== 8'h20) begin bad++; $display("FAIL jmp_stalled got=%b/%h want=0/20", bus.op_valid, bus.rom_addr); end
    wait_valid(cyc, to);
    total++; if (to || bus.im !== m_im(rom[8'h20]) || bus.illegal !== m_ill(rom[8'h20])) begin bad++; $display("FAIL jmp_stalled_word got=%h/%b want=%h/%b", bus.im, bus.illegal, m_im(rom[8'h20]), m_ill(rom[8'h20])); end
    bus.jmp = 1'b1;
    bus.jmp_addr = 8'h30;
    tick();
    bus.jmp = 1'b0;
    total++; if (bus.rom_addr !== 8'h30) begin bad++; $display("FAIL jmp_accept_addr got=%h want=30", bus.rom_addr); end
  endtask

  task automatic test_random();
    logic [7:0]  exp_addr;
    logic [14:0] held;
    bit in_pres;
    int acc;
    int low_run;
    int cyc;
    bus.jmp = 1'b1;
    bus.jmp_addr = 8'h80;
    tick();
    bus.jmp = 1'b0;
    exp_addr = 8'h80;
    in_pres = 1'b0;
    acc = 0;
    low_run = 0;
    cyc = 0;
    while (acc < 24 && cyc < 400) begin
      if (bus.op_valid) begin
        if (!in_pres) begin
          in_pres = 1'b1;
          total++; if (low_run != 2) begin bad++; $display("FAIL rnd_gap got=%0d want=2", low_run); end
          total++;
          if (bus.rom_addr !== exp_addr || bus.sel_b !== m_sel(rom[exp_addr]) || bus.im !== m_im(rom[exp_addr]) ||
              bus.alu_op !== m_op(rom[exp_addr]) || bus.illegal !== m_ill(rom[exp_addr])) begin
            bad++;
            $display("FAIL rnd_word got=%h:%b/%h/%h/%b want=%h:%b/%h/%h/%b", bus.rom_addr, bus.sel_b, bus.im, bus.alu_op, bus.illegal,
                     exp_addr, m_sel(rom[exp_addr]), m_im(rom[exp_addr]), m_op(rom[exp_addr]), m_ill(rom[exp_addr]));
          end
          held = {bus.sel_b, bus.im, bus.alu_op, bus.illegal};
        end else begin
          total++;
          if ({bus.sel_b, bus.im, bus.alu_op, bus.illegal} !== held || bus.rom_addr !== exp_addr) begin
            bad++;
            $display("FAIL rnd_hold got=%h want=%h", {bus.sel_b, bus.im, bus.alu_op, bus.illegal}, held);
          end
        end
        bus.stall = 1'($urandom % 2);
        if (!bus.stall) begin
          in_pres = 1'b0;
          exp_addr = exp_addr + 8'd1;
          acc++;
          low_run = 0;
        end
      end else begin
        low_run++;
        bus.stall = 1'($urandom % 2);
      end
      tick();
      cyc++;
    end
    bus.stall = 1'b0;
    total++; if (acc != 24) begin bad++; $display("FAIL rnd_accepted got=%0d want=24", acc); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    wait_valid(cyc, to);
    bus.stall = 1'b1;
    tick();
    total++; if (to || bus.op_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", bus.op_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.op_valid !== 1'b0 || bus.sel_b !== 2'b01) begin bad++; $display("FAIL rstmid_async got=%b/%b want=0/01", bus.op_valid, bus.sel_b); end
    total++; if (bus.rom_addr !== 8'h00 || bus.im !== 8'h00 || bus.alu_op !== 4'h0 || bus.illegal !== 1'b0) begin bad++; $display("FAIL rstmid_fields got=%h/%h/%h/%b want=00/00/0/0", bus.rom_addr, bus.im, bus.alu_op, bus.illegal); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.stall = 1'b0;
    wait_valid(cyc, to);
    total++; if (to || cyc != 2 || bus.rom_addr !== 8'h00 || bus.im !== 8'h05) begin bad++; $display("FAIL rstmid_refetch got=%0d/%h/%h want=2/00/05", cyc, bus.rom_addr, bus.im); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.jmp = 1'b0;
    bus.jmp_addr = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0]     = 16'h8305;
    rom[1]     = 16'h0100;
    rom[2]     = 16'h4700;
    rom[3]     = 16'hC2AA;
    rom[4]     = 16'h81FF;
    rom[7]     = 16'hC9EE;
    rom[8'h40] = 16'h2A5C;
    test_reset();
    test_first_fetch();
    test_sequence();
    test_stall();
    test_jump();
    test_wrap();
    test_jmp_in_issue();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_b_decoder.md
# operand_b_decoder

Instruction fetch/decode front end that produces the ALU B-operand controls: it walks an 8-bit program counter over a synchronous 16-bit instruction ROM, splits each word into opcode and literal, and drives the 2-bit B-operand select, the 8-bit immediate and the ALU opcode. It sits upstream of the B-operand multiplexer, whose select encoding it generates:

- 00: register B
- 01: constant zero
- 10: immediate

Decoded instructions go to the datapath through a valid/stall handshake.

## Interface
Parameters:
- none; widths are fixed (8-bit PC/data, 16-bit instruction).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  datapath not ready; holds the presented instruction.
- jmp  in  1  load PC with jmp_addr; abandon the in-flight fetch.
- jmp_addr  in  8  jump target.
- rom_addr  out  8  ROM address; equals PC.
- rom_data  in  16  ROM word; valid in the cycle after rom_addr is sampled at a clock edge.
- sel_b  out  2  B-operand select (00 B, 01 zero, 10 immediate).
- im  out  8  immediate (literal field).
- alu_op  out  4  ALU operation.
- op_valid  out  1  decoded instruction presented.
- illegal  out  1  presented instruction has reserved B-source code 11.

## Operation
Instruction word fields:
- [15:14]: B-source.
- [13:12]: reserved; ignored.
- [11:8]: alu_op.
- [7:0]: literal.

Decode:
- B-source 00 → sel_b=00; 01 → sel_b=01; 10 → sel_b=10.
- B-source 11 → sel_b=01 (zero) and illegal=1.
- im = literal for every instruction, whatever the B-source.

FSM states FETCH, LOAD, ISSUE:
- FETCH: rom_addr=PC is sampled by the ROM at the ending edge. Next state LOAD.
- LOAD: rom_data is valid. At the ending edge, register sel_b, im, alu_op and illegal from rom_data, and set op_valid=1. Next state ISSUE.
- ISSUE: outputs held stable.
  - stall=1: remain in ISSUE.
  - stall=0: the instruction is accepted at this edge. Clear op_valid, set PC←PC+1 (mod 256; 255 wraps to 0), next state FETCH.
- jmp=1 in any state takes priority:
  - PC←jmp_addr, op_valid←0, next state FETCH.
  - Any fetch in LOAD is discarded.
  - A presented instruction is discarded if stall=1, and counts as accepted if stall=0; either way PC takes jmp_addr, not PC+1.
  - sel_b, im, alu_op and illegal keep their last values and are meaningful only while op_valid=1.
- Decode outputs change only at the LOAD→ISSUE edge.

## Timing
- Reset values, applied immediately on rst high:
  - PC=0, state=FETCH, rom_addr=0.
  - sel_b=01, im=0, alu_op=0, op_valid=0, illegal=0.
- First ROM access after reset release: the first rising edge samples address 0. op_valid rises after the 2nd edge.
- Latency from PC update to op_valid=1: 2 edges. Unstalled throughput is one instruction per 3 cycles.
- op_valid stays high for exactly one cycle when stall=0, and for 1+N cycles with N stalled cycles.
- rst asserted mid-operation (any state): all of the above return to reset values asynchronously. The unaccepted instruction is lost. Restart is at address 0.
- jmp and stall=0 in the same ISSUE cycle: accepted, PC=jmp_addr.

## Test plan
- Reset, ROM[0]=16'h8305, stall=0 → after the 2nd edge: sel_b=10, im=05, alu_op=3, op_valid=1 for one cycle; rom_addr then becomes 1.
- ROM[1]=16'h0100, ROM[2]=16'h4700, ROM[3]=16'hC2AA → sel_b sequence 00, 01, 01. Only the third instruction has illegal=1, with im=AA.
- Stall held 4 cycles while instruction 16'h81FF is presented → op_valid high 5 cycles with outputs constant. PC advances only after stall falls.
- Pulse jmp with jmp_addr=8'h40 during LOAD of address 7 → address-7 word never presented. rom_addr=40 in the next FETCH, and the next op_valid carries ROM[40].
- Run to PC=FF, unstalled → after acceptance rom_addr=00, and ROM[0] is presented again.
- Assert rst in ISSUE with stall=1 → op_valid=0, sel_b=01 immediately (before the next edge). After release, ROM[0] is refetched.
